// File: rtl/codificador_4x2_sync_pkg.sv
// Shared types and helpers for the 4-to-2 one-hot encoder (and the matching decoder bench).
package codificador_4x2_sync_pkg;

    typedef enum logic [1:0] {
        OCIOSO         = 2'b00,
        ESTABILIZANDO  = 2'b01,
        AGUARDA_SOLTAR = 2'b10
    } estado_t;

    localparam logic [3:0] OH_0 = 4'b0001;
    localparam logic [3:0] OH_1 = 4'b0010;
    localparam logic [3:0] OH_2 = 4'b0100;
    localparam logic [3:0] OH_3 = 4'b1000;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v == OH_0) || (v == OH_1) || (v == OH_2) || (v == OH_3);
    endfunction

    // Highest set bit wins, so the same function serves one-hot and priority encoding.
    function automatic logic [1:0] encode(input logic [3:0] v);
        if (v[3])
            return 2'd3;
        else if (v[2])
            return 2'd2;
        else if (v[1])
            return 2'd1;
        else
            return 2'd0;
    endfunction

endpackage

// File: rtl/codificador_4x2_sync_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs, cleared to zero by an async active-high reset.
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/codificador_4x2_sync.sv
// Debounced, registered 4-to-2 one-hot encoder with Valido/Erro pulses.
// Define CODIFICADOR_PRIORIDADE_EN to encode multi-hot patterns by their highest bit instead of flagging Erro.
module codificador_4x2_sync
    import codificador_4x2_sync_pkg::*;
#(
    parameter int ESTAVEL_CICLOS = 4,
    parameter int CNT_W          = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Entrada,
    output logic [1:0] Codigo,
    output logic       Valido,
    output logic       Erro,
    output logic       Ocupado
);

    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(ESTAVEL_CICLOS - 1);

    logic [3:0]       s2;
    logic [3:0]       cap;
    logic [CNT_W-1:0] cnt;
    estado_t          estado;

    sincronizador_2ff #(.W(4)) u_sinc (
        .clk (Clock),
        .rst (Reset),
        .d   (Entrada),
        .q   (s2)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado  <= OCIOSO;
            cap     <= '0;
            cnt     <= '0;
            Codigo  <= 2'd0;
            Valido  <= 1'b0;
            Erro    <= 1'b0;
            Ocupado <= 1'b0;
        end else begin
            Valido <= 1'b0;
            Erro   <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (s2 != 4'b0000) begin
                        cap     <= s2;
                        cnt     <= CNT_W'(1);
                        estado  <= ESTABILIZANDO;
                        Ocupado <= 1'b1;
                    end
                end
                ESTABILIZANDO: begin
                    if (s2 != cap) begin
                        if (s2 == 4'b0000) begin
                            cnt     <= '0;
                            estado  <= OCIOSO;
                            Ocupado <= 1'b0;
                        end else begin
                            // Bounce to another pattern restarts the stability window.
                            cap <= s2;
                            cnt <= CNT_W'(1);
                        end
                    end else if (cnt == LIMITE) begin
`ifdef CODIFICADOR_PRIORIDADE_EN
                        Codigo <= encode(cap);
                        Valido <= 1'b1;
`else
                        if (is_onehot(cap)) begin
                            Codigo <= encode(cap);
                            Valido <= 1'b1;
                        end else begin
                            Erro <= 1'b1;
                        end
`endif
                        estado <= AGUARDA_SOLTAR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                AGUARDA_SOLTAR: begin
                    if (s2 == 4'b0000) begin
                        cnt     <= '0;
                        estado  <= OCIOSO;
                        Ocupado <= 1'b0;
                    end
                end
                default: begin
                    cnt     <= '0;
                    estado  <= OCIOSO;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codificador_4x2_sync.sv
// Bench for codificador_4x2_sync: directed plan steps plus random patterns against a run-length model.
module tb_codificador_4x2_sync;

    localparam int E = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Entrada = 4'b0000;
    logic [1:0] Codigo;
    logic       Valido;
    logic       Erro;
    logic       Ocupado;

    int checks = 0;
    int errors = 0;

    // model state: delayed input, run length of identical non-zero samples, armed until release
    logic [3:0] d1, d2, last;
    int         run;
    bit         armed;
    logic [1:0] m_cod;
    logic       m_val, m_err, m_ocup;

    int vcount, ecount, stepn, vfirst;

    codificador_4x2_sync #(.ESTAVEL_CICLOS(E), .CNT_W(8)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Entrada (Entrada),
        .Codigo  (Codigo),
        .Valido  (Valido),
        .Erro    (Erro),
        .Ocupado (Ocupado)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        d1 = 4'b0000; d2 = 4'b0000; last = 4'b0000;
        run = 0; armed = 1'b1;
        m_cod = 2'd0; m_val = 1'b0; m_err = 1'b0; m_ocup = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        m_val = 1'b0;
        m_err = 1'b0;
        if (Reset) begin
            model_reset();
            return;
        end
        seen = d2;
        d2 = d1;
        d1 = Entrada;
        if (seen == 4'b0000) begin
            run = 0;
            armed = 1'b1;
        end else begin
            run = (seen == last) ? run + 1 : 1;
            if (armed && run == E) begin
                armed = 1'b0;
`ifdef CODIFICADOR_PRIORIDADE_EN
                m_val = 1'b1;
                m_cod = 2'($clog2(int'(seen) + 1) - 1);
`else
                if ($countones(seen) == 1) begin
                    m_val = 1'b1;
                    m_cod = 2'($clog2(int'(seen) + 1) - 1);
                end else begin
                    m_err = 1'b1;
                end
`endif
            end
        end
        last = seen;
        m_ocup = (seen != 4'b0000);
    endtask

    task automatic step(input logic [3:0] e, input logic r);
        @(negedge Clock);
        Entrada = e;
        Reset = r;
        @(posedge Clock);
        model_edge();
        #1;
        stepn++;
        if (Valido === 1'b1) begin
            vcount++;
            if (vfirst == 0) vfirst = stepn;
        end
        if (Erro === 1'b1) ecount++;
        chk("codigo", {2'b00, Codigo}, {2'b00, m_cod});
        chk("valido", {3'b000, Valido}, {3'b000, m_val});
        chk("erro", {3'b000, Erro}, {3'b000, m_err});
        chk("ocupado", {3'b000, Ocupado}, {3'b000, m_ocup});
    endtask

    task automatic hold(input logic [3:0] e, input int n);
        for (int i = 0; i < n; i++) step(e, 1'b0);
    endtask

    task automatic clr_counts();
        vcount = 0; ecount = 0; stepn = 0; vfirst = 0;
    endtask

    initial begin
        model_reset();
        clr_counts();

        // reset held with a pattern present: nothing may come out
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b1);

        clr_counts();
        step(4'b0100, 1'b0);
        hold(4'b0100, 9);
        chk("lat_first_pulse", 4'(vfirst), 4'(E + 2));
        chk("lat_pulses", 4'(vcount), 4'd1);
        chk("lat_codigo", {2'b00, Codigo}, 4'd2);
        hold(4'b0000, 4);

        clr_counts();
        hold(4'b0001, 7); hold(4'b0000, 3);
        hold(4'b0010, 7); hold(4'b0000, 3);
        hold(4'b0100, 7); hold(4'b0000, 3);
        hold(4'b1000, 7); hold(4'b0000, 3);
        chk("sweep_pulses", 4'(vcount), 4'd4);
        chk("sweep_codigo", {2'b00, Codigo}, 4'd3);

        clr_counts();
        for (int i = 0; i < 5; i++) begin
            hold(4'b0010, 2);
            hold(4'b0000, 2);
        end
        chk("bounce_no_pulse", 4'(vcount), 4'd0);
        hold(4'b0010, 8);
        chk("bounce_pulses", 4'(vcount), 4'd1);
        chk("bounce_codigo", {2'b00, Codigo}, 4'd1);
        hold(4'b0000, 3);

        hold(4'b0001, 7); hold(4'b0000, 3);
        clr_counts();
        hold(4'b1010, 8);
`ifdef CODIFICADOR_PRIORIDADE_EN
        chk("multi_valido", 4'(vcount), 4'd1);
        chk("multi_codigo", {2'b00, Codigo}, 4'd3);
`else
        chk("multi_erro", 4'(ecount), 4'd1);
        chk("multi_codigo", {2'b00, Codigo}, 4'd0);
`endif
        hold(4'b0000, 3);

        clr_counts();
        hold(4'b1000, 8);
        hold(4'b0001, 8);
        chk("nosolt_pulses", 4'(vcount), 4'd1);
        chk("nosolt_codigo", {2'b00, Codigo}, 4'd3);
        hold(4'b0000, 3);
        hold(4'b0001, 8);
        chk("solt_codigo", {2'b00, Codigo}, 4'd0);
        hold(4'b0000, 3);

        // asynchronous reset in the middle of a stability window
        hold(4'b0100, 4);
        #2 Reset = 1'b1;
        #1;
        chk("async_codigo", {2'b00, Codigo}, 4'd0);
        chk("async_ocupado", {3'b000, Ocupado}, 4'd0);
        chk("async_valido", {3'b000, Valido}, 4'd0);
        model_reset();
        clr_counts();
        hold(4'b0100, 10);
        chk("async_first_pulse", 4'(vfirst), 4'(E + 2));
        chk("async_pulses", 4'(vcount), 4'd1);
        hold(4'b0000, 3);

        // random patterns held for random durations
        for (int s = 0; s < 80; s++) begin
            logic [3:0] p;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 60) p = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 80) p = 4'b0000;
            else p = 4'($urandom_range(0, 15));
            hold(p, int'($urandom_range(1, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codificador_4x2_sync.md
Name: codificador_4x2_sync

Overview:
- Registered 4-to-2 one-hot encoder; the inverse of the team's 2-to-4 one-hot decoder.
- Samples an asynchronous 4-bit one-hot input (switches/buttons or decoder feedback) through a 2-flop synchronizer.
- Debounces the input: it must be stable for ESTAVEL_CICLOS consecutive samples.
- Then emits the 2-bit binary code with a one-cycle Valido pulse, or a one-cycle Erro pulse for an illegal pattern.
- Sits between the board inputs and the control FSMs that consume a 2-bit selection.

Parameters:
- ESTAVEL_CICLOS, 4: consecutive identical synchronized samples required before emission; legal range 2..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > ESTAVEL_CICLOS.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Entrada  input  4  raw, asynchronous one-hot input; 0000 = nothing pressed.
- Codigo  output  2  binary code of the last accepted pattern: 0001→00, 0010→01, 0100→10, 1000→11.
- Valido  output  1  one-cycle pulse when Codigo is updated.
- Erro  output  1  one-cycle pulse when a stable, non-zero, non-one-hot pattern is rejected.
- Ocupado  output  1  high whenever the FSM is not in OCIOSO.

Behaviour:
- Reset values: Codigo=00, Valido=0, Erro=0, Ocupado=0, sync flops=0000, FSM=OCIOSO, counter=0. Reset dominates every other event, including mid-operation.
- Synchronizer: s1<=Entrada, s2<=s1. The FSM sees only s2.
- OCIOSO:
  - s2==0000: stay.
  - s2!=0000: cap<=s2, cnt<=1, go to ESTABILIZANDO.
- ESTABILIZANDO:
  - s2!=cap and s2==0000: go to OCIOSO; no output.
  - s2!=cap and s2!=0000: cap<=s2, cnt<=1, stay (restart).
  - s2==cap and cnt<ESTAVEL_CICLOS-1: cnt++.
  - s2==cap and cnt==ESTAVEL_CICLOS-1: evaluate cap.
    - Exactly one bit set: Codigo<=encode(cap), Valido<=1.
    - Otherwise: Erro<=1, Codigo unchanged.
    - Either way, go to AGUARDA_SOLTAR.
- AGUARDA_SOLTAR:
  - Stay while s2!=0000, including pattern changes. No new emission until release.
  - s2==0000: go to OCIOSO.
- Latency: Entrada changes before edge T and stays stable. Valido/Erro is high in the cycle after edge T+ESTAVEL_CICLOS+1, for exactly one cycle.
- Codigo holds its value indefinitely between emissions.
- Valido and Erro are never high together.
- Ocupado is registered from the FSM state (high in ESTABILIZANDO and AGUARDA_SOLTAR).
- Any synchronized bounce before the count completes restarts the window; no partial emission.
- Counter never exceeds ESTAVEL_CICLOS-1 and never wraps.

Optional Feature:
- Macro: CODIFICADOR_PRIORIDADE_EN.
- Defined: a stable multi-hot pattern encodes its highest set bit (e.g. 0110→10), Valido pulses, and Erro is tied to 0.
- Undefined: multi-hot → Erro pulse, Codigo unchanged (default behaviour above).

Decomposition:
- Shared package:
  - FSM state typedef (OCIOSO, ESTABILIZANDO, AGUARDA_SOLTAR), 2-bit encoding.
  - One-hot constants 4'b0001..4'b1000.
  - encode/is_onehot functions, also usable by the decoder bench.
- One natural sub-module: sincronizador_2ff (parameterized width, async active-high reset to 0), instantiated with width 4.

Test Plan:
- Reset held, Entrada=0100 → outputs stay 00/0/0/0. Release reset, hold 0100 → one Valido pulse at edge T+5 (ESTAVEL_CICLOS=4), Codigo=10, Ocupado=1 until Entrada=0000 propagates.
- Sweep 0001, 0010, 0100, 1000, each with release (0000) in between → Codigo 00, 01, 10, 11 with exactly four Valido pulses.
- Entrada toggles 0010/0000 every 2 cycles for 20 cycles, then holds 0010 → no pulse during toggling; exactly one Valido, Codigo=01.
- Stable 1010:
  - Macro undefined → one Erro pulse, Codigo keeps its previous value.
  - Macro defined → Valido, Codigo=11.
- Hold 1000 after emission, change to 0001 without release → no second pulse; release then 0001 → Valido, Codigo=00.
- Assert Reset asynchronously mid-ESTABILIZANDO → outputs and Ocupado drop immediately, before the next edge; no pulse after deassertion until a new full stability window completes.
